// File: rtl/mips_mem_arbiter_pkg.sv
// Shared memory-side definitions: RAM byte-lane constants and the read-owner encoding
// used by the fetch/data arbiter. Pure declarations, no logic, no latency.
// Imported by the arbiter top and its priority sub-module.
package mips_mem_arbiter_pkg;

  // Byte lanes per RAM word and the all-lanes mask used on every read.
  localparam int          MEM_LANES     = 4;
  localparam logic [3:0]  MEM_BYTES_ALL = 4'b1111;

  // Starvation counter width: holds STARVE_MAX up to 15.
  localparam int          STARVE_W      = 4;

  // Owner of the read that is in flight through the RAM (answer due next cycle).
  localparam int          OWNER_W       = 2;
  typedef enum logic [OWNER_W-1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Owner to record for the read launched this cycle; stores and idle cycles leave nothing in flight.
  function automatic owner_e next_owner(input logic if_gnt, input logic d_gnt, input logic d_wren);
    owner_e o;
    o = OWN_NONE;
    if (if_gnt) begin
      o = OWN_IF;
    end else if (d_gnt && !d_wren) begin
      o = OWN_D;
    end
    return o;
  endfunction

endpackage

// File: rtl/mips_mem_prio.sv
// Fixed priority between fetch and data requests with a starvation override for fetch.
// Purely combinational: grants depend only on the requests and the current starvation count.
// Never grants both; a starved fetch takes the port even while data keeps requesting.
module mips_mem_prio
  import mips_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                i_if_req,
  input  logic                i_d_req,
  input  logic [STARVE_W-1:0] i_starve_cnt,
  output logic                o_if_gnt,
  output logic                o_d_gnt
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic w_starved;

  assign w_starved = (i_starve_cnt == STARVE_LIM);

  // Data normally wins; fetch wins when alone or once it has waited STARVE_MAX data grants.
  assign o_if_gnt  = i_if_req & (~i_d_req | w_starved);
  assign o_d_gnt   = i_d_req & ~o_if_gnt;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port RAM between the fetch and data ports of the MIPS core.
// Grants and the RAM command are combinational in the request cycle; read data returns one cycle later.
// A losing requester holds its request; stall tells the PC to hold while fetch is not granted.
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_wren,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_bytes,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // RAM side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [3:0]        mem_bytes,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  // pipeline control
  output logic              stall
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic                w_if_req_act;
  logic                w_d_req_act;
  logic                w_if_gnt;
  logic                w_d_gnt;
  logic                w_store;
  logic                w_if_rvalid;
  logic                w_d_rvalid;

  logic [STARVE_W-1:0] r_starve_cnt;
  owner_e              r_owner;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  // Requests are masked while reset is asserted so no grant or RAM write can leak out.
  assign w_if_req_act = if_req & reset_n;
  assign w_d_req_act  = d_req & reset_n;

  mips_mem_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .i_if_req     (w_if_req_act),
    .i_d_req      (w_d_req_act),
    .i_starve_cnt (r_starve_cnt),
    .o_if_gnt     (w_if_gnt),
    .o_d_gnt      (w_d_gnt)
  );

  assign w_store = w_d_gnt & d_wren;

  // Count data grants taken while fetch is waiting; any fetch grant or idle fetch restarts the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (w_if_gnt || !if_req) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt && (r_starve_cnt != STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Remember who launched the read now travelling through the RAM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= next_owner(w_if_gnt, w_d_gnt, d_wren);
    end
  end

  // Last granted address, presented again on idle cycles so the RAM address does not toggle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem_addr <= '0;
    end else if (w_if_gnt) begin
      r_mem_addr <= if_addr;
    end else if (w_d_gnt) begin
      r_mem_addr <= d_addr;
    end
  end

  // A read answer is only delivered outside reset, so a read caught by reset is dropped.
  assign w_if_rvalid = reset_n & (r_owner == OWN_IF);
  assign w_d_rvalid  = reset_n & (r_owner == OWN_D);

  // Capture each delivered read word so the rdata outputs hold it while rvalid is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_if_rvalid) begin
        r_if_rdata <= mem_q;
      end
      if (w_d_rvalid) begin
        r_d_rdata <= mem_q;
      end
    end
  end

  // RAM command: the granted requester drives it directly; reads always enable every lane.
  assign mem_addr  = (!reset_n) ? '0 :
                     w_if_gnt   ? if_addr :
                     w_d_gnt    ? d_addr  : r_mem_addr;
  assign mem_data  = w_d_gnt ? d_wdata : '0;
  assign mem_bytes = w_store ? d_bytes : MEM_BYTES_ALL;
  assign mem_wren  = w_store;

  // Client-facing outputs; rdata passes mem_q straight through in its valid cycle.
  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = w_if_rvalid;
  assign d_rvalid  = w_d_rvalid;
  assign if_rdata  = w_if_rvalid ? mem_q : r_if_rdata;
  assign d_rdata   = w_d_rvalid  ? mem_q : r_d_rdata;
  assign stall     = if_req & ~w_if_gnt;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for the fetch/data RAM arbiter: write-first RAM model, requesters that hold until granted,
// and a transaction-level reference (who wins, what data each read must return) checked every cycle.
// Directed scenarios pin the reference with literal values before a long randomized run.
module tb_mips_mem_arbiter;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_wren;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_bytes;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [3:0]        mem_bytes;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic              stall;

  always #5 clk = ~clk;

  mips_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_wren    (d_wren),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_bytes   (d_bytes),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_bytes (mem_bytes),
    .mem_wren  (mem_wren),
    .mem_q     (mem_q),
    .stall     (stall)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // Write-first synchronous RAM driven by the DUT's memory port.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_wren) begin
      ram[mem_addr] <= merge(ram[mem_addr], mem_data, mem_bytes);
      mem_q         <= merge(ram[mem_addr], mem_data, mem_bytes);
    end else begin
      mem_q <= ram[mem_addr];
    end
  end

  // Reference state: shadow memory, waiting time of fetch, the read due next cycle, held read words.
  logic [31:0]       shadow [DEPTH];
  int                m_starve;
  int                m_pend;      // 0 nothing due, 1 fetch answer due, 2 load answer due
  logic [31:0]       m_pend_dat;
  logic [31:0]       m_if_rd;
  logic [31:0]       m_d_rd;
  logic [ADDR_W-1:0] m_addr;
  bit                m_live = 1'b0;
  bit                e_if_gnt;
  bit                e_d_gnt;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
  endtask

  // Called #1 after inputs settle: derive this cycle's expected outputs and compare.
  task automatic eval();
    logic [ADDR_W-1:0] ea;
    logic              rv_if;
    logic              rv_d;
    #1;
    if (!reset_n) begin
      e_if_gnt = 1'b0;
      e_d_gnt  = 1'b0;
    end else begin
      e_if_gnt = if_req && (!d_req || m_starve == STARVE_MAX);
      e_d_gnt  = d_req && !e_if_gnt;
    end
    if (m_live) begin
      rv_if = reset_n && (m_pend == 1);
      rv_d  = reset_n && (m_pend == 2);
      ea    = e_if_gnt ? if_addr : (e_d_gnt ? d_addr : (reset_n ? m_addr : '0));
      chk("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
      chk("d_gnt",     32'(d_gnt),     32'(e_d_gnt));
      chk("stall",     32'(stall),     32'(if_req && !e_if_gnt));
      chk("mem_wren",  32'(mem_wren),  32'(e_d_gnt && d_wren));
      chk("mem_addr",  32'(mem_addr),  32'(ea));
      chk("if_rvalid", 32'(if_rvalid), 32'(rv_if));
      chk("d_rvalid",  32'(d_rvalid),  32'(rv_d));
      chk("if_rdata",  if_rdata,       rv_if ? m_pend_dat : m_if_rd);
      chk("d_rdata",   d_rdata,        rv_d  ? m_pend_dat : m_d_rd);
      if (e_if_gnt || (e_d_gnt && !d_wren)) chk("mem_bytes_rd", 32'(mem_bytes), 32'hF);
      if (e_d_gnt && d_wren) begin
        chk("mem_bytes_wr", 32'(mem_bytes), 32'(d_bytes));
        chk("mem_data",     mem_data,       d_wdata);
      end
    end
  endtask

  // Apply the clock edge to the reference, then wait for the next driving point.
  task automatic commit();
    if (!reset_n) begin
      m_starve = 0;
      m_pend   = 0;
      m_if_rd  = '0;
      m_d_rd   = '0;
      m_addr   = '0;
      m_live   = 1'b1;
    end else begin
      if (m_pend == 1) m_if_rd = m_pend_dat;
      if (m_pend == 2) m_d_rd  = m_pend_dat;
      if (!if_req || e_if_gnt) m_starve = 0;
      else if (e_d_gnt && m_starve < STARVE_MAX) m_starve++;
      m_pend = 0;
      if (e_if_gnt) begin
        m_pend     = 1;
        m_pend_dat = shadow[if_addr];
        m_addr     = if_addr;
      end
      if (e_d_gnt) begin
        m_addr = d_addr;
        if (d_wren) begin
          shadow[d_addr] = merge(shadow[d_addr], d_wdata, d_bytes);
        end else begin
          m_pend     = 2;
          m_pend_dat = shadow[d_addr];
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [9:0] pat;
    int         rst_left;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = $urandom;
      shadow[i] = ram[i];
    end
    ram[3] = 32'hDEADBEEF;  shadow[3] = 32'hDEADBEEF;
    ram[5] = 32'hA5A50005;  shadow[5] = 32'hA5A50005;
    ram[7] = 32'h0BADF00D;  shadow[7] = 32'h0BADF00D;

    reset_n = 1'b0;
    if_req  = 1'b1;  if_addr = 6'd3;
    d_req   = 1'b0;  d_wren  = 1'b0;  d_addr = '0;  d_wdata = '0;  d_bytes = '0;
    eval(); commit();

    // Reset state with fetch requesting: no grant, stall follows if_req, registers cleared.
    eval();
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_stall",  32'(stall),  32'd1);
    chk("rst_maddr",  32'(mem_addr), 32'd0);
    chk("rst_ifrd",   if_rdata, 32'd0);
    chk("rst_drd",    d_rdata,  32'd0);
    commit();

    // Lone fetch of address 3.
    reset_n = 1'b1;
    eval();
    chk("f3_gnt",   32'(if_gnt), 32'd1);
    chk("f3_stall", 32'(stall),  32'd0);
    commit();
    if_req = 1'b0;
    eval();
    chk("f3_rvalid", 32'(if_rvalid), 32'd1);
    chk("f3_rdata",  if_rdata, 32'hDEADBEEF);
    commit();

    // Fetch and load of address 5 together: data first, fetch next.
    if_req = 1'b1; if_addr = 6'd5;
    d_req  = 1'b1; d_wren  = 1'b0; d_addr = 6'd5;
    eval();
    chk("c5_dgnt",  32'(d_gnt), 32'd1);
    chk("c5_stall", 32'(stall), 32'd1);
    commit();
    d_req = 1'b0;
    eval();
    chk("c5_ifgnt",  32'(if_gnt),   32'd1);
    chk("c5_drv",    32'(d_rvalid), 32'd1);
    chk("c5_drdata", d_rdata, 32'hA5A50005);
    commit();
    if_req = 1'b0;
    eval();
    chk("c5_ifrv",    32'(if_rvalid), 32'd1);
    chk("c5_ifrdata", if_rdata, 32'hA5A50005);
    commit();

    // Both held: four data grants then one fetch grant, repeating.
    pat = '0;
    if_req = 1'b1; if_addr = 6'd1;
    d_req  = 1'b1; d_wren  = 1'b0; d_addr = 6'd2;
    for (int c = 0; c < 10; c++) begin
      eval();
      pat = {pat[8:0], d_gnt};
      commit();
    end
    chk("starve_pattern", 32'(pat), 32'(10'b1111011110));
    if_req = 1'b0; d_req = 1'b0;
    eval(); commit();

    // Store then load of address 7.
    d_req = 1'b1; d_wren = 1'b1; d_addr = 6'd7; d_wdata = 32'h12345678; d_bytes = 4'b1111;
    eval();
    chk("st7_wren", 32'(mem_wren), 32'd1);
    commit();
    d_wren = 1'b0;
    eval();
    chk("st7_norv", 32'(d_rvalid), 32'd0);
    chk("ld7_wren", 32'(mem_wren), 32'd0);
    commit();
    d_req = 1'b0;
    eval();
    chk("ld7_rv",    32'(d_rvalid), 32'd1);
    chk("ld7_rdata", d_rdata, 32'h12345678);
    commit();

    // Reset arrives right after a fetch grant: its answer is dropped.
    if_req = 1'b1; if_addr = 6'd9;
    eval();
    chk("rs_gnt", 32'(if_gnt), 32'd1);
    commit();
    if_req = 1'b0; reset_n = 1'b0;
    eval();
    chk("rs_norv",  32'(if_rvalid), 32'd0);
    chk("rs_maddr", 32'(mem_addr),  32'd0);
    chk("rs_wren",  32'(mem_wren),  32'd0);
    commit();
    reset_n = 1'b1;
    eval();
    chk("rs_after_rv", 32'(if_rvalid), 32'd0);
    chk("rs_after_rd", if_rdata, 32'd0);
    commit();
    if_req = 1'b1; if_addr = 6'd3;
    eval();
    chk("rs_resume_gnt", 32'(if_gnt), 32'd1);
    commit();
    if_req = 1'b0;
    eval();
    chk("rs_resume_rd", if_rdata, 32'hDEADBEEF);
    commit();

    // Randomized traffic with occasional resets; addresses kept narrow so loads hit stores.
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = int'($urandom_range(1, 3));
      reset_n = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req  = 1'b1;
        if_addr = 6'($urandom_range(0, 15));
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req   = 1'b1;
        d_wren  = 1'($urandom_range(0, 1));
        d_addr  = 6'($urandom_range(0, 15));
        d_wdata = $urandom;
        d_bytes = 4'($urandom);
      end
      eval();
      commit();
      if (e_if_gnt) if_req = 1'b0;
      if (e_d_gnt)  d_req  = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, word-address width of the shared RAM.
REQ-002 Parameter DATA_W, default 32, RAM word width.
REQ-003 Parameter STARVE_MAX, default 4, maximum number of consecutive data grants while fetch waits; range 1..15.
REQ-004 Port clk, input, 1, carried in the ctrl bundle; sole clock, rising edge.
REQ-005 Port reset_n, input, 1, carried in the ctrl bundle; reset is synchronous and active-low.
REQ-006 Port if_req, input, 1, fetch read request; held until granted.
REQ-007 Port if_addr, input, ADDR_W, fetch word address.
REQ-008 Port if_gnt, output, 1, fetch request accepted this cycle.
REQ-009 Port if_rvalid, output, 1, if_rdata valid this cycle.
REQ-010 Port if_rdata, output, DATA_W, fetch read data.
REQ-011 Port d_req, input, 1, data request; held until granted.
REQ-012 Port d_wren, input, 1, 1 = store, 0 = load.
REQ-013 Port d_addr, input, ADDR_W, data word address.
REQ-014 Port d_wdata, input, DATA_W, store data.
REQ-015 Port d_bytes, input, 4, store byte enables.
REQ-016 Port d_gnt, output, 1, data request accepted this cycle.
REQ-017 Port d_rvalid, output, 1, d_rdata valid this cycle (loads only).
REQ-018 Port d_rdata, output, DATA_W, load data.
REQ-019 Port mem_addr, output, ADDR_W, RAM address.
REQ-020 Port mem_data, output, DATA_W, RAM write data.
REQ-021 Port mem_bytes, output, 4, RAM byte enables; 4'b1111 on reads.
REQ-022 Port mem_wren, output, 1, RAM write enable.
REQ-023 Port mem_q, input, DATA_W, RAM read data; valid one cycle after the address is presented.
REQ-024 Port stall, output, 1, high when if_req=1 and if_gnt=0; drives the PC hold.

Function
REQ-025 At most one of if_gnt and d_gnt is high in any cycle; the grant is combinational from the requests and the current state.
REQ-026 mem_addr, mem_data, mem_bytes and mem_wren reflect the granted requester's command in the grant cycle; with no grant, mem_wren=0 and mem_addr holds its previous value.
REQ-027 Arbitration: d_req wins over if_req unless starve_cnt==STARVE_MAX, in which case if_req wins.
REQ-028 starve_cnt increments on each cycle in which d_gnt=1 and if_req=1, and clears on if_gnt or when if_req=0; it saturates at STARVE_MAX.
REQ-029 A read owner register records the outstanding read with states NONE, IF and D: it loads IF on if_gnt, loads D on a d_gnt with d_wren=0, and loads NONE otherwise.
REQ-030 In the cycle after a read grant, the block asserts exactly one of if_rvalid or d_rvalid according to the owner, and the matching rdata equals mem_q.
REQ-031 Stores produce no rvalid, and the owner becomes NONE.
REQ-032 Back-to-back grants are allowed every cycle, giving a throughput of 1 access per cycle; read latency is 1 cycle from grant to rvalid.
REQ-033 if_rdata and d_rdata hold their last valid value when the corresponding rvalid is low.
REQ-034 When a store and a load of the same address are granted in consecutive cycles, the load returns the new data, relying on RAM write-first behaviour; the block adds no bypass.

Reset
REQ-035 While reset_n=0 at a clock edge: owner=NONE, starve_cnt=0, rdata registers=0, mem_addr=0.
REQ-036 During reset, all gnt and rvalid outputs are 0 and mem_wren=0; stall equals if_req.
REQ-037 A read granted in the cycle before reset has its rvalid suppressed; the request is not replayed.

Structure
REQ-038 The owner encoding (NONE, IF, D) and its width belong in the shared Mem package beside the RAM definitions.
REQ-039 The priority and starvation logic lives in one sub-module, mips_mem_prio (inputs: requests and starve_cnt; outputs: grants).
REQ-040 The block instantiates no RAM; it sits between the fetch and data ports and Memory_ram.

Verification
REQ-041 Only if_req=1, addr 3, with mem[3]=0xDEADBEEF -> if_gnt same cycle, if_rvalid next cycle, if_rdata=0xDEADBEEF, stall=0.
REQ-042 Simultaneous if_req and d_req load, addr 5 -> d_gnt first and stall=1; if_gnt the following cycle; d_rvalid and if_rvalid in successive cycles.
REQ-043 d_req held continuously with STARVE_MAX=4 and if_req held -> 4 d_gnts, then 1 if_gnt, then starve_cnt=0 and the pattern repeats.
REQ-044 Store 0x12345678 to addr 7 with bytes 4'b1111, then load addr 7 -> mem_wren=1 for one cycle with no rvalid; the load returns 0x12345678.
REQ-045 reset_n=0 in the cycle after an if_gnt -> no if_rvalid, all outputs at reset values, and normal operation resumes the cycle after reset_n=1.
